ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test initiator for the single-port `ram` block. It drives the RAM's `we`/`addr`/`data_in` as master and checks `data_out`.
- Runs a March C- sequence over addresses 0..2^addr_width-1 and reports pass/fail plus first-failure diagnostics.
- Sits between the top-level control pins and a `ram` instance; the RAM's own ports are unchanged.

Parameters:
- addr_width, 4, RAM address width; N = 2^addr_width cells tested.
- data_width, 4, RAM data width; the all-ones pattern is {data_width{1'b1}}.

Ports:
- clk  input  1  clock; RAM shares it.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled; begins a test when in IDLE or DONE.
- busy  output  1  high while a march element is executing.
- done  output  1  high in DONE; held until next start or rst.
- pass  output  1  valid when done=1; 1 means no mismatch.
- fail_elem  output  3  element index (1..5) of the first mismatch.
- fail_addr  output  addr_width  address of the first mismatch.
- fail_data  output  data_width  ram_rdata value captured at the first mismatch.
- ram_we  output  1  to ram.we.
- ram_addr  output  addr_width  to ram.addr.
- ram_wdata  output  data_width  to ram.data_in.
- ram_rdata  input  data_width  from ram.data_out.

Behaviour:
RAM timing contract:
- The RAM latches addr on each posedge and presents mem[latched addr] combinationally.
- A read issued in cycle k (ram_addr=A, ram_we=0) is compared against ram_rdata in cycle k+1.

March elements (P0 = all zeros, P1 = all ones):
- M0 ⇑(w0)
- M1 ⇑(r0,w1)
- M2 ⇑(r1,w0)
- M3 ⇓(r0,w1)
- M4 ⇓(r1,w0)
- M5 ⇓(r0)

Per-address cycle costs:
- Write-only element: 1 cycle per address (ram_we=1).
- Read-then-write element: 2 cycles per address.
  - Cycle A issues the read (we=0, addr=A).
  - Cycle B compares ram_rdata to the expected value and drives we=1, addr=A, write pattern. The compare sees the pre-write value.
- M5: cycle A issues, cycle B compares with we=0.
- Total march length is 11·N cycles (176 at defaults).

States and transitions:
- States: IDLE, M0..M5 (each with an ISSUE/CHECK phase bit for M1..M5), DONE.
- IDLE/DONE with start=1 → M0 at addr 0. At that edge, clear pass/fail fields and set done=0, busy=1.
- Address counter: ascending elements run 0→N-1; descending elements run N-1→0.
- On the last address of an element, go to the next element. Its starting address is 0 for ⇑ and N-1 for ⇓.
- After the M5 check at addr 0 → DONE with pass=1, done=1, busy=0.
- Mismatch on a CHECK cycle:
  - Capture fail_elem, fail_addr and fail_data (ram_rdata) at that edge.
  - pass=0, go directly to DONE. The pending write in that cycle is still issued.
- start while busy is ignored.

Output rules:
- ram_we, ram_addr and ram_wdata are decoded from current state/counter with no extra latency.
- In IDLE/DONE: ram_we=0, ram_addr=0, ram_wdata=0.
- ram_wdata equals the active element's write pattern throughout that element (M5: 0).
- Address N of the RAM's storage is never accessed.

Reset:
- After a rst edge, state is IDLE and busy, done and pass are 0.
- fail_elem, fail_addr and fail_data are 0; the address counter is 0.
- rst mid-march aborts with no further RAM writes after that edge. RAM contents are left as-is.

Test Plan:
1. rst, then 1-cycle start with a fault-free ram(4,4) → busy=1 for exactly 176 cycles; done=1, pass=1 on the following edge; final RAM cells 0..15 all 4'h0.
2. RAM model with bit0 of addr 5 stuck-at-1 → fail_elem=1, fail_addr=5, fail_data=4'h1, pass=0, done=1. No further ram_we after the failing cycle's write.
3. Aliasing model (write to addr 2 also writes addr 10) → fail_elem=1, fail_addr=10, fail_data=4'hF, pass=0.
4. start re-asserted at cycle 50 of a run → ignored; done still rises at cycle 176; pass=1.
5. rst asserted at cycle 80 → next cycle busy=0, done=0, ram_we=0. A new start then runs the full 176 cycles to pass=1.
6. After pass, hold start=0 for 20 cycles → done=1 and pass=1 stable. Pulse start → done=0, busy=1 next cycle; fail fields cleared.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator for a single-port synchronous-address RAM.
// Drives ram_we/ram_addr/ram_wdata as master and checks ram_rdata one cycle after each read.
//
// Ports:
//   clk, rst              shared clock; synchronous active-high reset
//   start                 level-sampled; launches a test from IDLE or DONE
//   busy                  high while a march element is executing
//   done, pass            test finished / finished with no mismatch
//   fail_elem/addr/data   element (1..5), address and read value of the first mismatch
//   ram_we/addr/wdata     RAM master outputs, decoded from state with no added latency
//   ram_rdata             RAM read data (mem[address latched on the previous edge])
module ram_march_bist #(
    parameter int addr_width = 4,
    parameter int data_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            fail_elem,
    output logic [addr_width-1:0] fail_addr,
    output logic [data_width-1:0] fail_data,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_wdata,
    input  logic [data_width-1:0] ram_rdata
);

    // M1..M5 are encoded as their own element index so the failing
    // element can be captured straight from the state register.
    localparam logic [2:0] S_M0   = 3'd0;
    localparam logic [2:0] S_M1   = 3'd1;
    localparam logic [2:0] S_M2   = 3'd2;
    localparam logic [2:0] S_M3   = 3'd3;
    localparam logic [2:0] S_M4   = 3'd4;
    localparam logic [2:0] S_M5   = 3'd5;
    localparam logic [2:0] S_IDLE = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [addr_width-1:0] ADDR_MAX = '1;
    localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);
    localparam logic [data_width-1:0] ONES     = '1;

    logic [2:0]            state_q, state_d;
    logic                  phase_q, phase_d;   // 0: issue read, 1: check
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  pass_q, pass_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [addr_width-1:0] fail_addr_q, fail_addr_d;
    logic [data_width-1:0] fail_data_q, fail_data_d;

    logic                  in_march;
    logic                  ascending;
    logic                  last_addr;
    logic                  mismatch;
    logic [data_width-1:0] exp_pat;
    logic [data_width-1:0] wr_pat;

    always_comb begin
        in_march  = (state_q <= S_M5);
        ascending = (state_q == S_M0) || (state_q == S_M1) || (state_q == S_M2);
        last_addr = ascending ? (addr_q == ADDR_MAX) : (addr_q == '0);
        exp_pat   = ((state_q == S_M2) || (state_q == S_M4)) ? ONES : '0;
        wr_pat    = ((state_q == S_M1) || (state_q == S_M3)) ? ONES : '0;
        mismatch  = in_march && (state_q != S_M0) && phase_q
                    && (ram_rdata != exp_pat);
    end

    always_comb begin
        busy      = in_march;
        done      = (state_q == S_DONE);
        pass      = pass_q;
        fail_elem = fail_elem_q;
        fail_addr = fail_addr_q;
        fail_data = fail_data_q;
        ram_addr  = in_march ? addr_q : '0;
        ram_wdata = in_march ? wr_pat : '0;
        // M0 writes every cycle; M1..M4 write on the check cycle; M5 only reads.
        ram_we    = (state_q == S_M0)
                    || (phase_q && (state_q >= S_M1) && (state_q <= S_M4));
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        fail_elem_d = fail_elem_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_M0;
                    phase_d     = 1'b0;
                    addr_d      = '0;
                    pass_d      = 1'b0;
                    fail_elem_d = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_M0: begin
                if (last_addr) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            default: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (mismatch) begin
                        // The write decoded this cycle still goes out.
                        state_d     = S_DONE;
                        pass_d      = 1'b0;
                        addr_d      = '0;
                        fail_elem_d = state_q;
                        fail_addr_d = addr_q;
                        fail_data_d = ram_rdata;
                    end else if (last_addr) begin
                        if (state_q == S_M5) begin
                            state_d = S_DONE;
                            pass_d  = 1'b1;
                            addr_d  = '0;
                        end else begin
                            state_d = state_q + 3'd1;
                            // Only M2 is ascending among the successors.
                            addr_d  = (state_q == S_M1) ? '0 : ADDR_MAX;
                        end
                    end else if (ascending) begin
                        addr_d = addr_q + ADDR_ONE;
                    end else begin
                        addr_d = addr_q - ADDR_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            fail_elem_q <= fail_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: RAM model with injectable faults, a March C- script
// model and a per-cycle compare process, plus directed literal checks.
module tb_ram_march_bist;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_march_bist #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: fault 0 none, 1 bit0 of cell 5 reads as 1, 2 writes to 2 alias into 10
    int            fault = 0;
    bit            scramble = 1'b0;
    logic [DW-1:0] mem [N];
    logic [AW-1:0] ram_a = '0;

    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < N; i++) mem[i] <= DW'($urandom);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            if (fault == 2 && ram_addr == AW'(2)) mem[10] <= ram_wdata;
        end
        ram_a <= ram_addr;
    end

    assign ram_rdata = mem[ram_a] | ((fault == 1 && ram_a == AW'(5)) ? DW'(1) : DW'(0));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // March C- as a flat per-cycle script built from the element table
    typedef struct {
        bit we;
        int addr;
        int wdata;
        bit chk;
        int exp;
        int elem;
    } op_t;

    op_t script[$];

    function automatic void build_script();
        int wp[6]  = '{0, N-1, 0, N-1, 0, 0};
        int ev[6]  = '{0, 0, N-1, 0, N-1, 0};
        int ones   = (1 << DW) - 1;
        script.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < N; i++) begin
                int a = (e < 3) ? i : N - 1 - i;
                int p = (wp[e] != 0) ? ones : 0;
                int x = (ev[e] != 0) ? ones : 0;
                if (e == 0) begin
                    script.push_back('{1'b1, a, p, 1'b0, 0, 0});
                end else begin
                    script.push_back('{1'b0, a, p, 1'b0, 0, e});
                    script.push_back('{(e != 5), a, p, 1'b1, x, e});
                end
            end
        end
    endfunction

    // Behavioural model state
    bit m_run = 0, m_done = 0, m_pass = 0;
    int m_idx = 0, m_fe = 0, m_fa = 0, m_fd = 0;
    bit cmp_en = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 0; m_done = 0; m_pass = 0;
                m_fe = 0; m_fa = 0; m_fd = 0; m_idx = 0;
            end else if (m_run) begin
                if (script[m_idx].chk && int'(ram_rdata) != script[m_idx].exp) begin
                    m_run = 0; m_done = 1; m_pass = 0;
                    m_fe = script[m_idx].elem;
                    m_fa = script[m_idx].addr;
                    m_fd = int'(ram_rdata);
                end else if (m_idx == script.size() - 1) begin
                    m_run = 0; m_done = 1; m_pass = 1;
                end else begin
                    m_idx++;
                end
            end else if (start) begin
                m_run = 1; m_idx = 0; m_done = 0; m_pass = 0;
                m_fe = 0; m_fa = 0; m_fd = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("busy", 32'(busy), 32'(m_run));
                check("done", 32'(done), 32'(m_done));
                check("pass", 32'(pass), 32'(m_pass));
                check("fail_elem", 32'(fail_elem), 32'(m_fe));
                check("fail_addr", 32'(fail_addr), 32'(m_fa));
                check("fail_data", 32'(fail_data), 32'(m_fd));
                check("ram_we", 32'(ram_we), m_run ? 32'(script[m_idx].we) : 0);
                check("ram_addr", 32'(ram_addr), m_run ? script[m_idx].addr : 0);
                check("ram_wdata", 32'(ram_wdata), m_run ? script[m_idx].wdata : 0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles; optional restart pulse and reset at given cycle
    task automatic run_count(output int cyc, input int restart_at, input int rst_at);
        cyc = 0;
        while (busy && cyc < 400) begin
            start = (cyc == restart_at);
            rst   = (cyc == rst_at);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        if (cyc >= 400) check("run_timeout", 32'(cyc), 32'(176));
    endtask

    int cyc;
    int len, pulse_at, rst_at;

    initial begin
        build_script();
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check("script_len", 32'(script.size()), 32'(176));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));

        // 1: fault-free run
        pulse_start();
        run_count(cyc, -1, -1);
        check("t1_busy_cycles", 32'(cyc), 32'(176));
        check("t1_done", 32'(done), 32'(1));
        check("t1_pass", 32'(pass), 32'(1));
        for (int i = 0; i < N; i++) check("t1_cell", 32'(mem[i]), 32'(0));

        // 2: stuck-at-1 on bit0 of cell 5
        fault = 1;
        pulse_start();
        run_count(cyc, -1, -1);
        check("t2_fail_elem", 32'(fail_elem), 32'(1));
        check("t2_fail_addr", 32'(fail_addr), 32'(5));
        check("t2_fail_data", 32'(fail_data), 32'(1));
        check("t2_pass", 32'(pass), 32'(0));
        check("t2_done", 32'(done), 32'(1));
        len = 0;
        repeat (10) begin
            len += int'(ram_we);
            @(negedge clk);
        end
        check("t2_no_writes", 32'(len), 32'(0));

        // 3: address aliasing 2 -> 10
        fault = 2;
        pulse_start();
        run_count(cyc, -1, -1);
        check("t3_fail_elem", 32'(fail_elem), 32'(1));
        check("t3_fail_addr", 32'(fail_addr), 32'(10));
        check("t3_fail_data", 32'(fail_data), 32'(15));
        check("t3_pass", 32'(pass), 32'(0));

        // 4: start re-asserted mid-run is ignored
        fault = 0;
        pulse_start();
        run_count(cyc, 50, -1);
        check("t4_busy_cycles", 32'(cyc), 32'(176));
        check("t4_pass", 32'(pass), 32'(1));

        // 5: reset mid-run, then a full rerun
        pulse_start();
        run_count(cyc, -1, 80);
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_done", 32'(done), 32'(0));
        check("t5_we", 32'(ram_we), 32'(0));
        pulse_start();
        run_count(cyc, -1, -1);
        check("t5_busy_cycles", 32'(cyc), 32'(176));
        check("t5_pass", 32'(pass), 32'(1));

        // 6: DONE holds, then restart clears results
        repeat (20) begin
            @(negedge clk);
            check("t6_hold", {30'b0, done, pass}, 32'(3));
        end
        pulse_start();
        check("t6_done", 32'(done), 32'(0));
        check("t6_busy", 32'(busy), 32'(1));
        check("t6_fail", {fail_elem, fail_addr, fail_data}, 32'(0));
        run_count(cyc, -1, -1);

        // Randomized scenarios checked by the model every cycle
        repeat (8) begin
            fault    = int'($urandom_range(0, 2));
            len      = int'($urandom_range(1, 3));
            pulse_at = int'($urandom_range(10, 190));
            rst_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 170)) : -1;
            scramble = 1'b1;
            @(negedge clk);
            scramble = 1'b0;
            for (int c = 0; c < 200; c++) begin
                start = (c < len) || (c == pulse_at);
                rst   = (c == rst_at);
                @(negedge clk);
            end
            start = 1'b0;
            rst   = 1'b0;
        end

        // Drain: let any run finish with a bounded wait
        cyc = 0;
        while (busy && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        check("drain_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
